// File: rtl/pe_pkg.sv
// Shared constants for the pe_dbw systolic processing element.
package pe_pkg;

  localparam int unsigned PE_DW   = 16;
  localparam int unsigned PE_FRAC = 10;

  localparam logic PE_MODE_WS = 1'b0;
  localparam logic PE_MODE_OS = 1'b1;

  // Signed limits of a PE_DW-bit result.
  localparam logic signed [PE_DW-1:0] PE_SAT_MAX = {1'b0, {(PE_DW-1){1'b1}}};
  localparam logic signed [PE_DW-1:0] PE_SAT_MIN = {1'b1, {(PE_DW-1){1'b0}}};

endpackage

// File: rtl/pe_mul_rs.sv
// Combinational multiply, round, shift, add and saturate/wrap with overflow detect.
module pe_mul_rs
  import pe_pkg::*;
#(
  parameter int unsigned DW   = PE_DW,
  parameter int unsigned FRAC = PE_FRAC,
  parameter int unsigned RND  = 1,
  parameter int unsigned SAT  = 1
) (
  input  logic signed [DW-1:0] a_i,
  input  logic signed [DW-1:0] b_i,
  input  logic signed [DW-1:0] addend_i,
  output logic signed [DW-1:0] sum_c_o,
  output logic                 ovf_c_o
);

  localparam int unsigned PW = 2 * DW;
  localparam int unsigned XW = DW + 2;

  localparam logic signed [PW-1:0] RND_K  = (RND != 0) ? (PW'(1) << (FRAC - 1)) : PW'(0);
  localparam logic signed [DW-1:0] MAX_DW = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] MIN_DW = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [XW-1:0] MAX_X  = XW'(MAX_DW);
  localparam logic signed [XW-1:0] MIN_X  = XW'(MIN_DW);

  logic signed [PW-1:0] prod_c;
  logic signed [XW-1:0] shf_c;
  logic signed [XW-1:0] sum_x_c;
  logic                 ovf_c;

  // Product is rounded in full width, then narrowed to DW+2 bits after the shift.
  always_comb begin
    prod_c  = PW'(a_i) * PW'(b_i);
    shf_c   = XW'((prod_c + RND_K) >>> FRAC);
    sum_x_c = shf_c + XW'(addend_i);
    ovf_c   = (sum_x_c > MAX_X) || (sum_x_c < MIN_X);
    sum_c_o = sum_x_c[DW-1:0];
    if (ovf_c && (SAT != 0)) begin
      sum_c_o = sum_x_c[XW-1] ? MIN_DW : MAX_DW;
    end
    ovf_c_o = ovf_c;
  end

endmodule

// File: rtl/pe_dbw.sv
// Systolic MAC cell: double-buffered weights, WS pass-through sum or OS accumulate with drain chain.
module pe_dbw
  import pe_pkg::*;
#(
  parameter int unsigned DW   = PE_DW,
  parameter int unsigned FRAC = PE_FRAC,
  parameter int unsigned RND  = 1,
  parameter int unsigned SAT  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mode,
  input  logic [DW-1:0] act_in,
  input  logic          act_valid_in,
  output logic [DW-1:0] act_out,
  output logic          act_valid_out,
  input  logic [DW-1:0] w_in,
  input  logic          w_load,
  input  logic          w_swap,
  output logic [DW-1:0] w_out,
  input  logic [DW-1:0] psum_in,
  input  logic          psum_valid_in,
  output logic [DW-1:0] psum_out,
  output logic          psum_valid_out,
  input  logic          os_clear,
  input  logic          os_drain,
  input  logic          flag_clr,
  output logic          ovf_flag
);

  logic [DW-1:0] act_q,      act_d;
  logic          act_vld_q,  act_vld_d;
  logic [DW-1:0] w_sh_q,     w_sh_d;
  logic [DW-1:0] w_act_q,    w_act_d;
  logic [DW-1:0] acc_q,      acc_d;
  logic [DW-1:0] psum_q,     psum_d;
  logic          psum_vld_q, psum_vld_d;
  logic          ovf_q,      ovf_d;

  logic [DW-1:0] addend_c;
  logic [DW-1:0] sum_c;
  logic          ovf_c;
  logic          os_restart_c;

  assign os_restart_c = os_clear | os_drain;

  // A clear or drain restarts the accumulator, so the product enters with a zero addend.
  always_comb begin
    addend_c = psum_in;
    if (mode == PE_MODE_OS) begin
      addend_c = os_restart_c ? '0 : acc_q;
    end
  end

  pe_mul_rs #(
    .DW   (DW),
    .FRAC (FRAC),
    .RND  (RND),
    .SAT  (SAT)
  ) u_mul (
    .a_i      (act_in),
    .b_i      (w_act_q),
    .addend_i (addend_c),
    .sum_c_o  (sum_c),
    .ovf_c_o  (ovf_c)
  );

  always_comb begin
    act_d      = act_valid_in ? act_in : act_q;
    act_vld_d  = act_valid_in;
    w_sh_d     = w_load ? w_in : w_sh_q;
    w_act_d    = w_swap ? w_sh_q : w_act_q;
    acc_d      = acc_q;
    psum_d     = psum_q;
    psum_vld_d = 1'b0;
    ovf_d      = (ovf_q & ~flag_clr) | (act_valid_in & ovf_c);

    if (mode == PE_MODE_WS) begin
      if (act_valid_in) begin
        psum_d     = sum_c;
        psum_vld_d = 1'b1;
      end
    end else begin
      if (os_restart_c) begin
        acc_d = act_valid_in ? sum_c : '0;
      end else if (act_valid_in) begin
        acc_d = sum_c;
      end
      // Draining this cell takes priority over forwarding the northern chain.
      if (os_drain) begin
        psum_d     = acc_q;
        psum_vld_d = 1'b1;
      end else begin
        psum_d     = psum_in;
        psum_vld_d = psum_valid_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q      <= '0;
      act_vld_q  <= 1'b0;
      w_sh_q     <= '0;
      w_act_q    <= '0;
      acc_q      <= '0;
      psum_q     <= '0;
      psum_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      act_q      <= act_d;
      act_vld_q  <= act_vld_d;
      w_sh_q     <= w_sh_d;
      w_act_q    <= w_act_d;
      acc_q      <= acc_d;
      psum_q     <= psum_d;
      psum_vld_q <= psum_vld_d;
      ovf_q      <= ovf_d;
    end
  end

  assign act_out        = act_q;
  assign act_valid_out  = act_vld_q;
  assign w_out          = w_sh_q;
  assign psum_out       = psum_q;
  assign psum_valid_out = psum_vld_q;
  assign ovf_flag       = ovf_q;

endmodule
